// File: rtl/led_pkg.sv
// Shared types for the RGB LED arbiter: color codes, FSM states and the color decode.
package led_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b11,
    BLUE  = 2'b10
  } color_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  // Map a color code onto the three LED drives; BLANK and unknown codes are all-off.
  function automatic rgb_t color_to_rgb(input color_e c);
    rgb_t rgb;
    rgb = '0;
    case (c)
      RED:     rgb.r = 1'b1;
      GREEN:   rgb.g = 1'b1;
      BLUE:    rgb.b = 1'b1;
      default: rgb = '0;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: lowest (i - ptr) mod NUM_REQ among set request bits.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   pick
);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    any  = |req;
    pick = '0;
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      int idx;
      logic [IDX_W-1:0] idx_v;
      idx = int'(ptr) + j;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      idx_v = IDX_W'(idx);
      if (req[idx_v]) pick = idx_v;
    end
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin sharing of one RGB LED: show a granted color for its duration,
// then hold a fixed blank gap before the next grant.
module rgb_led_arbiter
  import led_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DUR_WIDTH  = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*2-1:0]           color,
  input  logic [NUM_REQ*DUR_WIDTH-1:0]   dur,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           done,
  output logic [$clog2(NUM_REQ)-1:0]     done_id,
  output logic                           busy,
  output logic                           red,
  output logic                           green,
  output logic                           blue
);

  localparam int unsigned IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [DUR_WIDTH-1:0] dur_cnt_q, dur_cnt_d;
  logic [DUR_WIDTH-1:0] dur_last_q, dur_last_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  color_e               color_q, color_d;
  logic [IDX_W-1:0]     id_q, id_d;

  logic [NUM_REQ-1:0]   grant_d;
  logic                 done_d;
  logic [IDX_W-1:0]     done_id_d;
  logic                 busy_d;
  rgb_t                 rgb_d;
  logic                 decide;

  logic                 any;
  logic [IDX_W-1:0]     pick;

  logic [1:0]           color_a [NUM_REQ];
  logic [DUR_WIDTH-1:0] dur_a   [NUM_REQ];

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign color_a[i] = color[2*i +: 2];
    assign dur_a[i]   = dur[DUR_WIDTH*i +: DUR_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req  (req),
    .ptr  (ptr_q),
    .any  (any),
    .pick (pick)
  );

  // Next-state and next-output logic; every output register is loaded from here.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dur_cnt_d  = dur_cnt_q;
    dur_last_d = dur_last_q;
    gap_cnt_d  = gap_cnt_q;
    color_d    = color_q;
    id_d       = id_q;
    grant_d    = '0;
    done_d     = 1'b0;
    done_id_d  = done_id;
    rgb_d      = '0;
    decide     = 1'b0;

    case (state_q)
      IDLE: decide = 1'b1;
      SHOW: begin
        if (dur_cnt_q == dur_last_q) begin
          done_d    = 1'b1;
          done_id_d = id_q;
          if (GAP_CYCLES == 0) begin
            decide = 1'b1;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end else begin
          dur_cnt_d = dur_cnt_q + DUR_WIDTH'(1);
          rgb_d     = color_to_rgb(color_q);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) decide = 1'b1;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Decision edge: grant the round-robin pick, or fall back to IDLE.
    if (decide) begin
      if (enable && any) begin
        state_d       = SHOW;
        dur_cnt_d     = '0;
        color_d       = color_e'(color_a[pick]);
        dur_last_d    = (dur_a[pick] == '0) ? '0 : dur_a[pick] - DUR_WIDTH'(1);
        id_d          = pick;
        grant_d[pick] = 1'b1;
        ptr_d         = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
        rgb_d         = color_to_rgb(color_e'(color_a[pick]));
      end else begin
        state_d = IDLE;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      dur_cnt_q  <= '0;
      dur_last_q <= '0;
      gap_cnt_q  <= '0;
      color_q    <= BLANK;
      id_q       <= '0;
      grant      <= '0;
      done       <= 1'b0;
      done_id    <= '0;
      busy       <= 1'b0;
      red        <= 1'b0;
      green      <= 1'b0;
      blue       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dur_cnt_q  <= dur_cnt_d;
      dur_last_q <= dur_last_d;
      gap_cnt_q  <= gap_cnt_d;
      color_q    <= color_d;
      id_q       <= id_d;
      grant      <= grant_d;
      done       <= done_d;
      done_id    <= done_id_d;
      busy       <= busy_d;
      red        <= rgb_d.r;
      green      <= rgb_d.g;
      blue       <= rgb_d.b;
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: two instances (gap 2 and gap 0) against a cycle-count reference model.
module tb_rgb_led_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [N-1:0]      req;
  logic [2*N-1:0]    color;
  logic [N*DW-1:0]   dur;

  logic [N-1:0] grant_a, grant_b;
  logic         done_a, done_b, busy_a, busy_b;
  logic [1:0]   done_id_a, done_id_b;
  logic         red_a, green_a, blue_a, red_b, green_b, blue_b;

  logic [10:0]  obs   [2];
  logic [10:0]  exp_o [2];

  int checks = 0;
  int errors = 0;

  // Reference model: display windows and decision cycles as plain cycle numbers.
  int         mc = 0;
  bit         m_idle [2];
  int         m_ptr [2], m_ss [2], m_se [2], m_dc [2], m_nx [2], m_id [2], m_did [2];
  logic [1:0] m_col [2];

  always #5 clk = ~clk;

  rgb_led_arbiter #(.NUM_REQ(N), .DUR_WIDTH(DW), .GAP_CYCLES(2)) u_gap2 (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .color(color), .dur(dur),
    .grant(grant_a), .done(done_a), .done_id(done_id_a), .busy(busy_a),
    .red(red_a), .green(green_a), .blue(blue_a));

  rgb_led_arbiter #(.NUM_REQ(N), .DUR_WIDTH(DW), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .color(color), .dur(dur),
    .grant(grant_b), .done(done_b), .done_id(done_id_b), .busy(busy_b),
    .red(red_b), .green(green_b), .blue(blue_b));

  assign obs[0] = {grant_a, done_a, done_id_a, busy_a, red_a, green_a, blue_a};
  assign obs[1] = {grant_b, done_b, done_id_b, busy_b, red_b, green_b, blue_b};

  function automatic logic [2:0] rgb_of(input logic [1:0] c);
    case (c)
      2'b01:   return 3'b100;
      2'b11:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_idle[m] = 1'b1; m_ptr[m] = 0; m_ss[m] = -1; m_se[m] = -2;
      m_dc[m] = -1; m_nx[m] = -1; m_id[m] = 0; m_did[m] = 0; m_col[m] = 2'b00;
      exp_o[m] = '0;
    end
  endtask

  task automatic model_step();
    mc++;
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0] g;
      logic         dn;
      logic [2:0]   rgb;
      int           gap, p, d;
      bit           found;
      gap = (m == 0) ? 2 : 0;
      if (reset) begin
        model_reset();
      end else begin
        g  = '0;
        dn = (mc == m_dc[m]);
        if (dn) m_did[m] = m_id[m];
        if (m_idle[m] || mc == m_nx[m]) begin
          if (enable && req != '0) begin
            found = 0; p = 0;
            for (int o = 0; o < N; o++) begin
              if (!found && req[(m_ptr[m] + o) % N]) begin
                p = (m_ptr[m] + o) % N; found = 1;
              end
            end
            d = int'(dur[p*DW +: DW]);
            if (d == 0) d = 1;
            g[p] = 1'b1;
            m_col[m] = color[p*2 +: 2];
            m_ss[m] = mc; m_se[m] = mc + d - 1; m_dc[m] = mc + d; m_nx[m] = mc + d + gap;
            m_id[m] = p; m_idle[m] = 1'b0; m_ptr[m] = (p + 1) % N;
          end else begin
            m_idle[m] = 1'b1;
          end
        end
        rgb = (mc >= m_ss[m] && mc <= m_se[m]) ? rgb_of(m_col[m]) : 3'b000;
        exp_o[m] = {g, dn, 2'(m_did[m]), !m_idle[m], rgb};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; req = '0; color = '0; dur = '0;
    repeat (3) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== 11'd0) begin
          errors++; $display("FAIL reset dut%0d got=%b want=%b", m, obs[m], 11'd0);
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int red_cnt = 0;
    enable = 1'b1; req = 4'b0010; color = 8'b00_00_01_00; dur = 32'h0000_0300;
    tick();
    checks++;
    if (grant_a !== 4'b0010) begin
      errors++; $display("FAIL single_grant got=%b want=%b", grant_a, 4'b0010);
    end
    req = '0;
    for (int c = 0; c < 10; c++) begin
      red_cnt += int'(red_a);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_o[m]) begin
          errors++; $display("FAIL single dut%0d cyc=%0d got=%b want=%b", m, mc, obs[m], exp_o[m]);
        end
      end
      tick();
    end
    checks++;
    if (red_cnt != 3) begin
      errors++; $display("FAIL single_red_len got=%0d want=%0d", red_cnt, 3);
    end
  endtask

  task automatic test_round_robin();
    int gid [$];
    int gcyc [$];
    int want [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; color = 8'b01_10_11_01; dur = 32'h0202_0202;
    for (int c = 0; c < 21; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (grant_a[i]) begin gid.push_back(i); gcyc.push_back(mc); end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_o[m]) begin
          errors++; $display("FAIL rr dut%0d cyc=%0d got=%b want=%b", m, mc, obs[m], exp_o[m]);
        end
      end
    end
    checks++;
    if (gid.size() < 5) begin
      errors++; $display("FAIL rr_count got=%0d want=%0d", gid.size(), 5);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gid[k] != want[k]) begin
          errors++; $display("FAIL rr_order k=%0d got=%0d want=%0d", k, gid[k], want[k]);
        end
        if (k > 0) begin
          checks++;
          if (gcyc[k] - gcyc[k-1] != 4) begin
            errors++; $display("FAIL rr_spacing k=%0d got=%0d want=%0d", k, gcyc[k] - gcyc[k-1], 4);
          end
        end
      end
    end
    req = '0;
  endtask

  task automatic test_zero();
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0011; color = 8'b00_00_10_11; dur = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) req = 4'b0010;
      else req = '0;
      if (c == 1) begin
        checks++;
        if ({done_b, grant_b, blue_b} !== {1'b1, 4'b0010, 1'b1}) begin
          errors++; $display("FAIL zero_chain got=%b want=%b", {done_b, grant_b, blue_b}, 6'b1_0010_1);
        end
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_o[m]) begin
          errors++; $display("FAIL zero dut%0d cyc=%0d got=%b want=%b", m, mc, obs[m], exp_o[m]);
        end
      end
    end
  endtask

  task automatic test_enable();
    enable = 1'b0; req = 4'b0100; color = 8'b00_01_00_00; dur = 32'h0003_0000;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (grant_a !== 4'b0000) begin
        errors++; $display("FAIL enable_low_grant got=%b want=%b", grant_a, 4'b0000);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (grant_a !== 4'b0100) begin
      errors++; $display("FAIL enable_rise_grant got=%b want=%b", grant_a, 4'b0100);
    end
    tick();
    enable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_o[m]) begin
          errors++; $display("FAIL enable dut%0d cyc=%0d got=%b want=%b", m, mc, obs[m], exp_o[m]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; req = 4'b1000; color = 8'b10_00_00_00; dur = 32'h0500_0000;
    tick(); req = '0;
    tick();
    #2 reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== 11'd0) begin
        errors++; $display("FAIL reset_mid_async dut%0d got=%b want=%b", m, obs[m], 11'd0);
      end
    end
    model_reset();
    tick();
    reset = 1'b0; req = 4'b1001; color = 8'b10_00_00_01; dur = 32'h0500_0002;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        checks++;
        if (grant_a !== 4'b0001) begin
          errors++; $display("FAIL reset_mid_ptr got=%b want=%b", grant_a, 4'b0001);
        end
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_o[m]) begin
          errors++; $display("FAIL reset_mid dut%0d cyc=%0d got=%b want=%b", m, mc, obs[m], exp_o[m]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_stability();
    int green_cnt = 0;
    repeat (8) tick();
    enable = 1'b1; req = 4'b0001; color = 8'b00_00_00_11; dur = 32'h0000_0004;
    for (int c = 0; c < 9; c++) begin
      tick();
      req = '0; color = 8'($urandom); dur = $urandom;
      green_cnt += int'(green_a);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_o[m]) begin
          errors++; $display("FAIL stable dut%0d cyc=%0d got=%b want=%b", m, mc, obs[m], exp_o[m]);
        end
      end
    end
    checks++;
    if (green_cnt < 4) begin
      errors++; $display("FAIL stable_len got=%0d want>=%0d", green_cnt, 4);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req    = 4'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      color  = 8'($urandom);
      for (int i = 0; i < N; i++) dur[i*DW +: DW] = 8'($urandom_range(0, 4));
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== exp_o[m]) begin
          errors++; $display("FAIL random dut%0d cyc=%0d got=%b want=%b", m, mc, obs[m], exp_o[m]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_zero();
    test_enable();
    test_reset_mid();
    test_stability();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
